// File: rtl/hermes_pkg.sv
// Shared definitions for the Hermes local-port transmitter: default sizes,
// router port indices and the transmit FSM encoding.
package hermes_pkg;

  localparam int DEF_FLIT_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;
  localparam int LOCAL = 4;
  localparam int NPORT = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_SIZE    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_END     = 3'd4
  } tx_fsm_t;

endpackage

// File: rtl/hermes_tx_fifo.sv
// Payload buffer for the local transmitter. Besides the current head it
// exposes the head as it will be after this cycle's push/pop.
module hermes_tx_fifo
  import hermes_pkg::*;
#(
  parameter int FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FLIT_WIDTH-1:0] din,
  output logic [FLIT_WIDTH-1:0] dout,
  output logic [FLIT_WIDTH-1:0] dout_next,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FLIT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         rd_ptr_inc_s;
  logic [AW:0]           count_r;
  logic                  push_s;
  logic                  pop_s;

  assign full         = (count_r == (AW+1)'(FIFO_DEPTH));
  assign empty        = (count_r == {(AW+1){1'b0}});
  assign push_s       = push && !full;
  assign pop_s        = pop && !empty;
  assign rd_ptr_inc_s = rd_ptr_r + AW'(1);
  assign dout         = mem_r[rd_ptr_r];

  // Head after this cycle; a push into an empty (or emptying) FIFO becomes the head.
  always_comb begin
    dout_next = mem_r[rd_ptr_r];
    if (pop_s) begin
      if (count_r == (AW+1)'(1)) begin
        dout_next = din;
      end else begin
        dout_next = mem_r[rd_ptr_inc_s];
      end
    end else if (empty) begin
      dout_next = din;
    end else begin
      dout_next = mem_r[rd_ptr_r];
    end
  end

  // Storage array write.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hermes_local_tx.sv
// Hermes LOCAL-port packet transmitter: header, size, then payload flits,
// each moved only in a cycle where the downstream credit is high.
module hermes_local_tx
  import hermes_pkg::*;
#(
  parameter int FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FLIT_WIDTH/2-1:0] target,
  input  logic [FLIT_WIDTH-1:0]   size,
  input  logic                    pl_valid,
  input  logic [FLIT_WIDTH-1:0]   pl_data,
  output logic                    pl_ready,
  input  logic                    credit_i,
  output logic                    tx,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    done
);

  localparam int HALF = FLIT_WIDTH / 2;
  localparam logic [FLIT_WIDTH-1:0] ZERO_W = {FLIT_WIDTH{1'b0}};
  localparam logic [FLIT_WIDTH-1:0] ONE_W  = {{(FLIT_WIDTH-1){1'b0}}, 1'b1};

  tx_fsm_t               state_r;
  tx_fsm_t               state_next_s;
  logic [FLIT_WIDTH-1:0] size_r;
  logic [FLIT_WIDTH-1:0] acc_cnt_r;
  logic [FLIT_WIDTH-1:0] snd_cnt_r;
  logic [FLIT_WIDTH-1:0] data_out_r;
  logic [FLIT_WIDTH-1:0] data_out_next_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  start_acc_s;
  logic                  flit_pending_s;
  logic                  tx_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  pl_ready_s;
  logic                  flush_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FLIT_WIDTH-1:0] fifo_head_s;
  logic [FLIT_WIDTH-1:0] fifo_head_next_s;

  assign start_acc_s = (state_r == S_IDLE) && start;
  assign tx_s        = flit_pending_s && credit_i;
  assign pop_s       = tx_s && (state_r == S_PAYLOAD);
  assign pl_ready_s  = busy_r && (acc_cnt_r != ZERO_W) && !fifo_full_s;
  assign push_s      = pl_valid && pl_ready_s;
  assign flush_s     = (state_r == S_END);

  hermes_tx_fifo #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush_s),
    .push      (push_s),
    .pop       (pop_s),
    .din       (pl_data),
    .dout      (fifo_head_s),
    .dout_next (fifo_head_next_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:    state_next_s = start ? S_HEADER : S_IDLE;
      S_HEADER:  state_next_s = tx_s ? S_SIZE : S_HEADER;
      S_SIZE: begin
        if (tx_s) begin
          state_next_s = (size_r != ZERO_W) ? S_PAYLOAD : S_END;
        end else begin
          state_next_s = S_SIZE;
        end
      end
      S_PAYLOAD: begin
        if (tx_s && (snd_cnt_r == ONE_W)) begin
          state_next_s = S_END;
        end else begin
          state_next_s = S_PAYLOAD;
        end
      end
      S_END:     state_next_s = S_IDLE;
      default:   state_next_s = S_IDLE;
    endcase
  end

  // FSM outputs: whether a flit is on offer this cycle.
  always_comb begin
    flit_pending_s = 1'b0;
    case (state_r)
      S_HEADER:  flit_pending_s = 1'b1;
      S_SIZE:    flit_pending_s = 1'b1;
      S_PAYLOAD: flit_pending_s = !fifo_empty_s;
      default:   flit_pending_s = 1'b0;
    endcase
  end

  // Flit to present next cycle, chosen by the state being entered.
  always_comb begin
    data_out_next_s = ZERO_W;
    case (state_next_s)
      S_HEADER: begin
        if (state_r == S_IDLE) begin
          data_out_next_s = {{(FLIT_WIDTH-HALF){1'b0}}, target};
        end else begin
          data_out_next_s = data_out_r;
        end
      end
      S_SIZE:    data_out_next_s = size_r;
      S_PAYLOAD: begin
        if (fifo_empty_s || pop_s) begin
          data_out_next_s = fifo_head_next_s;
        end else begin
          data_out_next_s = fifo_head_s;
        end
      end
      default:   data_out_next_s = ZERO_W;
    endcase
  end

  // Captured size plus intake and send counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      size_r    <= ZERO_W;
      acc_cnt_r <= ZERO_W;
      snd_cnt_r <= ZERO_W;
    end else if (start_acc_s) begin
      size_r    <= size;
      acc_cnt_r <= size;
      snd_cnt_r <= size;
    end else begin
      if (push_s) begin
        acc_cnt_r <= acc_cnt_r - ONE_W;
      end
      if (pop_s) begin
        snd_cnt_r <= snd_cnt_r - ONE_W;
      end
    end
  end

  // Registered flit data and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_r <= ZERO_W;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      data_out_r <= data_out_next_s;
      busy_r     <= (state_next_s != S_IDLE);
      done_r     <= (state_next_s == S_END);
    end
  end

  assign tx       = tx_s;
  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pl_ready = pl_ready_s;

endmodule

// File: tb/tb_hermes_local_tx.sv
// Randomised scoreboard bench for hermes_local_tx: expected flit streams are
// queued when packets are issued and popped by a monitor on every transfer.
module tb_hermes_local_tx;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  target;
  logic [15:0] size;
  logic        pl_valid;
  logic [15:0] pl_data;
  logic        pl_ready;
  logic        credit_i = 1'b1;
  logic        tx;
  logic [15:0] data_out;
  logic        busy;
  logic        done;

  int checks      = 0;
  int passed      = 0;
  int accepted    = 0;
  int base_acc    = 0;
  int pl_gap      = 0;
  int idle_cnt    = 0;
  int bubble_cnt  = 0;
  int credit_mode = 0;
  bit rdy_seen    = 1'b0;
  bit prev_done   = 1'b0;
  logic [15:0] mon_exp;
  logic [15:0] pay_q[$];
  logic [15:0] pl_q[$];
  logic [15:0] exp_q[$];

  hermes_local_tx dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .target   (target),
    .size     (size),
    .pl_valid (pl_valid),
    .pl_data  (pl_data),
    .pl_ready (pl_ready),
    .credit_i (credit_i),
    .tx       (tx),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Credit generator: 0 always, 1 random, 2 toggling, 3 withheld.
  always @(posedge clock) begin
    #1;
    case (credit_mode)
      0:       credit_i = 1'b1;
      1:       credit_i = 1'($urandom_range(0, 1));
      2:       credit_i = ~credit_i;
      default: credit_i = 1'b0;
    endcase
  end

  // Payload producer: offers pl_q in order, idling pl_gap cycles after each accept.
  initial begin
    bit took;
    pl_valid = 1'b0;
    pl_data  = 16'h0000;
    forever begin
      @(negedge clock);
      took = pl_valid && pl_ready;
      @(posedge clock);
      #1;
      if (took && pl_q.size() > 0) begin
        void'(pl_q.pop_front());
        accepted++;
        idle_cnt = pl_gap;
      end
      if (idle_cnt > 0) begin
        idle_cnt--;
        pl_valid = 1'b0;
      end else if (pl_q.size() > 0) begin
        pl_valid = 1'b1;
        pl_data  = pl_q[0];
      end else begin
        pl_valid = 1'b0;
      end
    end
  end

  // Monitor: every transferred flit must be the next expected one.
  always @(negedge clock) begin
    if (reset) begin
      if (tx) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_flit: got data_out=%h, expected no flit", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("flit", data_out, mon_exp);
        end
      end
      if (pl_ready) rdy_seen = 1'b1;
      if (busy && credit_i && !tx && !done) bubble_cnt++;
      if (done) begin
        check("done_after_last", exp_q.size(), 0);
        check("done_single", prev_done, 1'b0);
      end
      prev_done = done;
    end
  end

  task automatic send_pkt(input logic [7:0] tgt, input logic [15:0] sz);
    base_acc = accepted;
    exp_q.push_back({8'h00, tgt});
    exp_q.push_back(sz);
    for (int i = 0; i < pay_q.size(); i++) begin
      pl_q.push_back(pay_q[i]);
      if (i < int'(sz)) exp_q.push_back(pay_q[i]);
    end
    @(posedge clock); #1;
    start  = 1'b1;
    target = tgt;
    size   = sz;
    @(posedge clock); #1;
    start  = 1'b0;
    target = 8'($urandom);
    size   = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clock);
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic post_pkt(input int sz);
    check("accepted", accepted - base_acc, sz);
    check("leftover", pl_q.size(), pay_q.size() - sz);
    pl_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic finish_pkt(input int sz, input int budget);
    wait_done(budget);
    post_pkt(sz);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    target = 8'h00;
    size = 16'h0000;
    repeat (2) @(negedge clock);
    check("rst_tx", tx, 1'b0);
    check("rst_data", data_out, 16'h0000);
    check("rst_ready", pl_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic packet with pre-offered payload
    pay_q = '{16'h0002};
    pl_gap = 0;
    send_pkt(8'h12, 16'd1);
    @(negedge clock); check("basic_hdr", {tx, data_out}, {1'b1, 16'h0012});
    @(negedge clock); check("basic_size", {tx, data_out}, {1'b1, 16'h0001});
    @(negedge clock); check("basic_pay", {tx, data_out}, {1'b1, 16'h0002});
    @(negedge clock); check("basic_done", {done, tx}, 2'b10);
    post_pkt(1);

    // Credit withheld for four cycles while the size flit is pending
    send_pkt(8'h12, 16'd1);
    @(negedge clock); check("stall_hdr", {tx, data_out}, {1'b1, 16'h0012});
    credit_mode = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); check("stall_hold", {tx, data_out}, {1'b0, 16'h0001});
    end
    credit_mode = 0;
    @(negedge clock); check("stall_resume", {tx, data_out}, {1'b1, 16'h0001});
    finish_pkt(1, 50);

    // Zero-size packet
    pay_q.delete();
    rdy_seen = 1'b0;
    send_pkt(8'h21, 16'd0);
    finish_pkt(0, 50);
    check("zero_no_ready", rdy_seen, 1'b0);

    // Starved payload with an extra word that must never be taken
    pay_q = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    pl_gap = 5;
    bubble_cnt = 0;
    send_pkt(8'h07, 16'd3);
    finish_pkt(3, 200);
    check("starve_bubbles", bubble_cnt > 0, 1'b1);

    // Start while busy is ignored
    pay_q.delete();
    for (int i = 0; i < 4; i++) pay_q.push_back(16'($urandom));
    pl_gap = 1;
    send_pkt(8'h44, 16'd4);
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1; target = 8'h33; size = 16'd7;
    @(posedge clock); #1;
    start = 1'b0;
    finish_pkt(4, 200);
    repeat (3) @(negedge clock);
    check("busy_start_ignored", busy, 1'b0);
    pay_q = '{16'h1111, 16'h2222};
    pl_gap = 0;
    send_pkt(8'h33, 16'd2);
    finish_pkt(2, 100);

    // Reset during the second of four payload flits
    pay_q.delete();
    for (int i = 0; i < 4; i++) pay_q.push_back(16'($urandom));
    send_pkt(8'h55, 16'd4);
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock); check("abort_flit1", {tx, data_out}, {1'b1, pay_q[0]});
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("abort_tx", tx, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_data", data_out, 16'h0000);
    check("abort_ready", pl_ready, 1'b0);
    exp_q.delete();
    @(negedge clock);
    pl_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    pay_q = '{16'hBEEF, 16'hCAFE};
    send_pkt(8'h66, 16'd2);
    finish_pkt(2, 100);

    // Random packets under random and toggling credit
    for (int p = 0; p < 8; p++) begin
      int sz;
      credit_mode = (p < 4) ? 1 : 2;
      sz = (p == 7) ? 40 : int'($urandom_range(0, 9));
      pay_q.delete();
      for (int i = 0; i < sz; i++) pay_q.push_back(16'($urandom));
      pl_gap = int'($urandom_range(0, 3));
      send_pkt(8'($urandom_range(0, 255)), 16'(sz));
      finish_pkt(sz, 800);
    end
    credit_mode = 0;
    repeat (3) @(posedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
